// File: rtl/demux4_seq_pkg.sv
// Shared constants for the 4-channel sequencing demux: FSM encoding,
// channel indices and the default sample width.
package demux4_seq_pkg;

  localparam int WIDTH_DEF = 8;

  localparam logic HUNT = 1'b0;
  localparam logic RUN  = 1'b1;

  typedef logic [1:0] ch_idx_t;

  localparam ch_idx_t CH0 = 2'd0;
  localparam ch_idx_t CH1 = 2'd1;
  localparam ch_idx_t CH2 = 2'd2;
  localparam ch_idx_t CH3 = 2'd3;

  typedef struct packed {
    logic    en;
    ch_idx_t ch;
  } wr_req_t;

  // Round-robin successor; the 2-bit width gives the 3 -> 0 wrap for free.
  function automatic ch_idx_t next_ch(input ch_idx_t ch);
    return ch + 2'd1;
  endfunction

endpackage

// File: rtl/dec2to4_en.sv
// Channel write-enable decode: 2-bit index plus enable to one-hot enables.
module dec2to4_en
  import demux4_seq_pkg::*;
(
  input  logic       en_i,
  input  ch_idx_t    idx_i,
  output logic [3:0] onehot_o
);

  always_comb begin
    onehot_o = 4'b0000;
    if (en_i) onehot_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/demux4_seq.sv
// Four-channel demux with explicit select or sync-aligned round-robin
// sequencing; all outputs are registered.
//
//   state | meaning
//   ------+--------------------------------------------------------
//   HUNT  | auto mode waiting for a sync sample; non-sync samples dropped
//   RUN   | aligned; samples go to the channel counter, frame_done on ch3
module demux4_seq
  import demux4_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             auto_mode,
  input  logic             s1,
  input  logic             s0,
  input  logic             sync,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [3:0]       out_valid,
  output logic             frame_done,
  output logic             locked
);

  logic             state_q, state_d;
  ch_idx_t          cnt_q, cnt_d;
  logic [3:0]       out_valid_q;
  logic             frame_done_q, frame_done_d;
  logic [WIDTH-1:0] out_q [4];
  wr_req_t          wr;
  logic [3:0]       wr_en;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;
    wr.en        = 1'b0;
    wr.ch        = CH0;
    if (!auto_mode) begin
      // Leaving auto mode drops alignment; while explicit these are already idle.
      state_d = HUNT;
      cnt_d   = CH0;
      if (in_valid) begin
        wr.en = 1'b1;
        wr.ch = {s1, s0};
      end
    end else if (in_valid) begin
      if (state_q == HUNT) begin
        if (sync) begin
          wr.en   = 1'b1;
          wr.ch   = CH0;
          cnt_d   = CH1;
          state_d = RUN;
        end
      end else if (sync && (cnt_q != CH0)) begin
        // Sync arrived mid-frame: restart the frame at ch0 without a frame_done.
        wr.en = 1'b1;
        wr.ch = CH0;
        cnt_d = CH1;
      end else begin
        wr.en        = 1'b1;
        wr.ch        = cnt_q;
        cnt_d        = next_ch(cnt_q);
        frame_done_d = (cnt_q == CH3);
      end
    end
  end

  dec2to4_en u_dec (
    .en_i     (wr.en),
    .idx_i    (wr.ch),
    .onehot_o (wr_en)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= HUNT;
      cnt_q        <= CH0;
      out_valid_q  <= 4'b0000;
      frame_done_q <= 1'b0;
      for (int i = 0; i < 4; i++) out_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= wr_en;
      frame_done_q <= frame_done_d;
      for (int i = 0; i < 4; i++) begin
        if (wr_en[i]) out_q[i] <= in_data;
      end
    end
  end

  assign out0       = out_q[0];
  assign out1       = out_q[1];
  assign out2       = out_q[2];
  assign out3       = out_q[3];
  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
  assign locked     = (state_q == RUN);

endmodule

// File: tb/tb_demux4_seq.sv
// Self-checking bench for demux4_seq: vector table, directed corner cases
// and a randomized run against a frame-level reference model.
module tb_demux4_seq;

  logic       clock;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       auto_mode;
  logic       s1;
  logic       s0;
  logic       sync;
  logic [7:0] out0, out1, out2, out3;
  logic [3:0] out_valid;
  logic       frame_done;
  logic       locked;

  demux4_seq #(.WIDTH(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .auto_mode  (auto_mode),
    .s1         (s1),
    .s0         (s0),
    .sync       (sync),
    .out0       (out0),
    .out1       (out1),
    .out2       (out2),
    .out3       (out3),
    .out_valid  (out_valid),
    .frame_done (frame_done),
    .locked     (locked)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: where in the frame the next sample lands, if aligned.
  bit         m_aligned;
  int         m_pos;
  logic [7:0] m_out [4];
  logic [3:0] m_ov;
  bit         m_fd;

  typedef struct {
    bit         iv;
    bit         am;
    int         sel;
    bit         sy;
    logic [7:0] d;
    logic [3:0] ov;
    bit         fd;
    bit         lk;
    int         ch;
    logic [7:0] dat;
  } vec_t;

  vec_t tbl [12];

  function automatic vec_t mk(bit iv, bit am, int sel, bit sy, logic [7:0] d,
                              logic [3:0] ov, bit fd, bit lk, int ch, logic [7:0] dat);
    vec_t v;
    v.iv = iv; v.am = am; v.sel = sel; v.sy = sy; v.d = d;
    v.ov = ov; v.fd = fd; v.lk = lk; v.ch = ch; v.dat = dat;
    return v;
  endfunction

  function automatic logic [7:0] dut_out(int i);
    case (i)
      0:       return out0;
      1:       return out1;
      2:       return out2;
      default: return out3;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit iv, input bit am, input int sel,
                            input bit sy, input logic [7:0] d);
    int tgt;
    tgt  = -1;
    m_fd = 1'b0;
    if (r) begin
      m_aligned = 1'b0;
      m_pos     = 0;
      for (int i = 0; i < 4; i++) m_out[i] = 8'h00;
    end else if (!am) begin
      m_aligned = 1'b0;
      m_pos     = 0;
      if (iv) tgt = sel;
    end else if (iv) begin
      if (!m_aligned) begin
        if (sy) begin
          tgt = 0; m_aligned = 1'b1; m_pos = 1;
        end
      end else if (sy && m_pos != 0) begin
        tgt = 0; m_pos = 1;
      end else begin
        tgt   = m_pos;
        m_fd  = (m_pos == 3);
        m_pos = (m_pos + 1) % 4;
      end
    end
    m_ov = 4'b0000;
    if (tgt >= 0) begin
      m_out[tgt] = d;
      m_ov[tgt]  = 1'b1;
    end
  endtask

  task automatic tick(input bit r, input bit iv, input bit am, input int sel,
                      input bit sy, input logic [7:0] d);
    reset     = r;
    in_valid  = iv;
    auto_mode = am;
    s1        = sel[1];
    s0        = sel[0];
    sync      = sy;
    in_data   = d;
    model_step(r, iv, am, sel, sy, d);
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all_clear(input string nm);
    chk({nm, "_out0"}, out0, 0);
    chk({nm, "_out1"}, out1, 0);
    chk({nm, "_out2"}, out2, 0);
    chk({nm, "_out3"}, out3, 0);
    chk({nm, "_ov"}, out_valid, 0);
    chk({nm, "_fd"}, frame_done, 0);
    chk({nm, "_lk"}, locked, 0);
  endtask

  int fd_count;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; auto_mode = 1'b0;
    s1 = 1'b0; s0 = 1'b0; sync = 1'b0;

    // Explicit-mode vectors followed by a hunt/lock frame.
    tbl[0]  = mk(1, 0, 2, 0, 8'hA2, 4'b0100, 0, 0, 2, 8'hA2);
    tbl[1]  = mk(1, 0, 1, 0, 8'hB1, 4'b0010, 0, 0, 1, 8'hB1);
    tbl[2]  = mk(1, 0, 3, 0, 8'hC3, 4'b1000, 0, 0, 3, 8'hC3);
    tbl[3]  = mk(1, 0, 0, 0, 8'hD0, 4'b0001, 0, 0, 0, 8'hD0);
    tbl[4]  = mk(0, 0, 1, 0, 8'hEE, 4'b0000, 0, 0, 2, 8'hA2);
    tbl[5]  = mk(1, 1, 0, 0, 8'h10, 4'b0000, 0, 0, 0, 8'hD0);
    tbl[6]  = mk(1, 1, 0, 0, 8'h11, 4'b0000, 0, 0, 1, 8'hB1);
    tbl[7]  = mk(1, 1, 0, 1, 8'h20, 4'b0001, 0, 1, 0, 8'h20);
    tbl[8]  = mk(1, 1, 0, 0, 8'h21, 4'b0010, 0, 1, 1, 8'h21);
    tbl[9]  = mk(1, 1, 0, 0, 8'h22, 4'b0100, 0, 1, 2, 8'h22);
    tbl[10] = mk(1, 1, 0, 0, 8'h23, 4'b1000, 1, 1, 3, 8'h23);
    tbl[11] = mk(0, 1, 0, 0, 8'h99, 4'b0000, 0, 1, 3, 8'h23);

    tick(1, 0, 0, 0, 0, 8'h00);
    tick(1, 0, 0, 0, 0, 8'h00);
    chk_all_clear("reset");

    for (int i = 0; i < 12; i++) begin
      tick(0, tbl[i].iv, tbl[i].am, tbl[i].sel, tbl[i].sy, tbl[i].d);
      chk($sformatf("vec%0d_ov", i), out_valid, tbl[i].ov);
      chk($sformatf("vec%0d_fd", i), frame_done, tbl[i].fd);
      chk($sformatf("vec%0d_lk", i), locked, tbl[i].lk);
      chk($sformatf("vec%0d_out%0d", i, tbl[i].ch), dut_out(tbl[i].ch), tbl[i].dat);
    end

    // Reset mid-frame after ch1: everything clears, no frame_done.
    tick(1, 0, 1, 0, 0, 8'h00);
    tick(0, 1, 1, 0, 1, 8'h30);
    tick(0, 1, 1, 0, 0, 8'h31);
    chk("midrst_pre_out1", out1, 8'h31);
    tick(1, 1, 1, 0, 0, 8'h32);
    chk_all_clear("midrst");
    tick(0, 1, 1, 0, 0, 8'h33);
    chk("postrst_nosync_ov", out_valid, 4'b0000);
    chk("postrst_nosync_fd", frame_done, 0);
    tick(0, 1, 1, 0, 1, 8'h34);
    chk("postrst_first_ov", out_valid, 4'b0001);
    chk("postrst_first_out0", out0, 8'h34);
    chk("postrst_first_lk", locked, 1);

    // Two frames with gaps at counter=2.
    tick(1, 0, 1, 0, 0, 8'h00);
    fd_count = 0;
    tick(0, 1, 1, 0, 1, 8'h01); fd_count += frame_done;
    tick(0, 1, 1, 0, 0, 8'h02); fd_count += frame_done;
    tick(0, 0, 1, 0, 0, 8'hFF); fd_count += frame_done;
    chk("gap1_ov", out_valid, 4'b0000);
    tick(0, 0, 1, 0, 1, 8'hFE); fd_count += frame_done;
    chk("gap2_ov", out_valid, 4'b0000);
    tick(0, 1, 1, 0, 0, 8'h03); fd_count += frame_done;
    chk("gap_resume_ov", out_valid, 4'b0100);
    chk("gap_resume_out2", out2, 8'h03);
    tick(0, 1, 1, 0, 0, 8'h04); fd_count += frame_done;
    chk("frame1_fd", frame_done, 1);
    tick(0, 1, 1, 0, 1, 8'h05); fd_count += frame_done;
    chk("frame2_sync_ov", out_valid, 4'b0001);
    tick(0, 1, 1, 0, 0, 8'h06); fd_count += frame_done;
    tick(0, 0, 1, 0, 0, 8'hFD); fd_count += frame_done;
    tick(0, 1, 1, 0, 0, 8'h07); fd_count += frame_done;
    chk("frame2_out2", out2, 8'h07);
    tick(0, 1, 1, 0, 0, 8'h08); fd_count += frame_done;
    tick(0, 0, 1, 0, 0, 8'h00); fd_count += frame_done;
    chk("frame2_out0", out0, 8'h05);
    chk("frame2_out1", out1, 8'h06);
    chk("frame2_out3", out3, 8'h08);
    chk("wrap_fd_count", fd_count, 2);

    // Re-alignment: sync at counter=2.
    tick(1, 0, 1, 0, 0, 8'h00);
    tick(0, 1, 1, 0, 1, 8'h40);
    tick(0, 1, 1, 0, 0, 8'h41);
    tick(0, 1, 1, 0, 1, 8'h55);
    chk("realign_ov", out_valid, 4'b0001);
    chk("realign_out0", out0, 8'h55);
    chk("realign_fd", frame_done, 0);
    chk("realign_lk", locked, 1);
    tick(0, 1, 1, 0, 0, 8'h56);
    chk("realign_next_ov", out_valid, 4'b0010);
    chk("realign_next_out1", out1, 8'h56);
    tick(0, 1, 1, 0, 0, 8'h57);
    chk("realign_ch2_fd", frame_done, 0);

    // Mode switch while locked.
    tick(1, 0, 1, 0, 0, 8'h00);
    tick(0, 1, 1, 0, 1, 8'h60);
    tick(0, 1, 1, 0, 0, 8'h61);
    chk("mode_pre_lk", locked, 1);
    tick(0, 0, 0, 0, 0, 8'h00);
    chk("mode_drop_lk", locked, 0);
    tick(0, 1, 1, 0, 0, 8'h62);
    chk("mode_back_nosync_ov", out_valid, 4'b0000);
    chk("mode_back_nosync_lk", locked, 0);
    tick(0, 1, 1, 0, 1, 8'h63);
    chk("mode_back_sync_ov", out_valid, 4'b0001);
    chk("mode_back_sync_out0", out0, 8'h63);
    chk("mode_back_sync_lk", locked, 1);

    // Randomized run against the reference model.
    tick(1, 0, 1, 0, 0, 8'h00);
    for (int c = 0; c < 600; c++) begin
      tick($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 7,
           $urandom_range(0, 19) != 0, int'($urandom_range(0, 3)),
           $urandom_range(0, 4) == 0, 8'($urandom));
      chk("rand_ov", out_valid, m_ov);
      chk("rand_fd", frame_done, m_fd);
      chk("rand_lk", locked, m_aligned);
      chk("rand_ov_onehot", ($countones(out_valid) <= 1), 1);
      for (int i = 0; i < 4; i++) chk($sformatf("rand_out%0d", i), dut_out(i), m_out[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
